iram_responder: RTL and testbench
=================================

Name: iram_responder

Overview:
Instruction-memory responder: the memory end of the fetch stage's IRead/Inst interface.
- Holds the program in an internal word array and returns the instruction word at the requested PC when IRead is asserted.
- A boot-load port fills the array after reset; CoreHold keeps the pipeline in reset until loading completes.
- Sits between the external program loader and the fetch stage.

Parameters:
ADDR_W, 8, word-address width; array depth = 2**ADDR_W words
NOP_WORD, 32'h00000000, word returned on error, hold or idle

Ports:
Clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
IRead  in  1  read enable from fetch, sampled at rising Clk
PC  in  32  byte address of requested instruction
Inst  out  32  registered instruction word to fetch
AddrErr  out  1  registered; PC misaligned or out of range on the last accepted read
LoadValid  in  1  loader presents LoadData
LoadData  in  32  instruction word to store
LoadLast  in  1  qualifies the final word of the load, valid with LoadValid
LoadReady  out  1  responder accepts a word this cycle
CoreHold  out  1  high until the program is loaded; drives the core's reset
LoadCount  out  ADDR_W+1  number of words stored

Behaviour:
- Reset (sampled high at a rising edge) has these effects:
  - State goes to LOAD.
  - Inst=NOP_WORD, AddrErr=0, LoadCount=0, CoreHold=1, LoadReady=0.
  - Array contents are not cleared.
  - The load pointer is cleared.
  - Reset mid-load or mid-run always restarts loading from word 0.
- States: LOAD, RUN.
- LOAD state:
  - LoadReady=1 combinationally, except on the cycle Reset is high.
  - A transfer occurs when LoadValid & LoadReady at a rising edge.
  - On a transfer: mem[ptr]<=LoadData, ptr and LoadCount increment.
  - Transfer with LoadLast=1 -> RUN on the next edge.
  - Transfer that fills word 2**ADDR_W-1 -> RUN even if LoadLast=0.
  - In LOAD, IRead is ignored; Inst holds NOP_WORD and AddrErr stays 0.
- Entering RUN:
  - CoreHold falls on the same edge.
  - LoadReady=0 and LoadValid is ignored.
  - LoadCount is frozen.
- RUN, read:
  - When IRead=1 at a rising edge, Inst<=mem[PC[ADDR_W+1:2]]: one-cycle latency, registered output.
  - When IRead=0, Inst and AddrErr hold.
- Error cases (IRead=1 and any of):
  - PC[1:0]!=0 -> Inst<=NOP_WORD, AddrErr<=1.
  - Any bit of PC[31:ADDR_W+2] set -> Inst<=NOP_WORD, AddrErr<=1.
  - Word index >= LoadCount (never loaded) -> Inst<=NOP_WORD, AddrErr<=1.
- A valid read clears AddrErr to 0.
- Simultaneous LoadLast transfer and IRead on the same edge: the read is ignored, because the state is still LOAD.
- Array: single write port (load) and single read port (fetch), both synchronous. Writes and reads never occur in the same state, so there are no read/write collisions.
- LoadCount width ADDR_W+1 so a full array reads 2**ADDR_W without wrap.

Decomposition:
- Shared package/header: NOP_WORD and state encodings LOAD=1'b0, RUN=1'b1. These are shared with the fetch and decode stages, which use the same NOP encoding.
- One natural sub-module: iram_array, a 2**ADDR_W x 32 synchronous RAM with ports WE/WAddr/WData and RE/RAddr/RData. It is infer-friendly; the responder wraps it with the FSM, range checks and error muxing.

Test Plan:
1. Reset, then load 4 words (0x20010005, 0x20020007, 0x00221820, 0xAC030000), LoadLast on the 4th -> CoreHold falls on the edge after the 4th transfer, and LoadCount=4. Then IRead with PC=0x8 -> Inst=0x00221820 one cycle later, AddrErr=0.
2. After load, PC=0x6 with IRead=1 -> Inst=0x00000000, AddrErr=1. Next read at PC=0x4 -> Inst=0x20020007, AddrErr=0.
3. With ADDR_W=8 and LoadCount=4:
   - PC=0x10 -> NOP, AddrErr=1.
   - PC=0x400 -> NOP, AddrErr=1.
   - PC=0xC -> 0xAC030000.
4. Load 256 words with LoadLast never asserted -> RUN after the 256th transfer, LoadCount=256, LoadReady=0. A further LoadValid is ignored.
5. Assert Reset for one cycle mid-run -> CoreHold=1, Inst=NOP, LoadCount=0. Reload 2 new words -> PC=0x0 returns the new word 0.
6. IRead held low in RUN for 5 cycles while PC changes -> Inst stays constant. Assert IRead together with LoadLast during LOAD -> Inst remains NOP.

Source files
------------

// File: rtl/iram_responder_pkg.sv
// Shared definitions for the instruction-memory responder and the fetch/decode stages.
// The NOP encoding here is the same one fetch and decode use.
package iram_responder_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/iram_array.sv
// Synchronous single-write / single-read word RAM holding the program image.
// Written in a form that maps onto block RAM.
module iram_array #(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WAddr,
   input  logic [31:0]       WData,
   input  logic              RE,
   input  logic [ADDR_W-1:0] RAddr,
   output logic [31:0]       RData
);

   logic [31:0] mem [2**ADDR_W];

   // Write port, driven only by the boot loader.
   always_ff @(posedge Clk) begin
      if (WE) begin
         mem[WAddr] <= WData;
      end
   end

   // Registered read port; the output holds whenever RE is low.
   always_ff @(posedge Clk) begin
      if (RE) begin
         RData <= mem[RAddr];
      end
   end

endmodule

// File: rtl/iram_responder.sv
// Memory end of the fetch interface: boot-load FSM, range checking and error muxing
// wrapped around the program RAM.
module iram_responder #(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = iram_responder_pkg::NOP_WORD
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              IRead,
   input  logic [31:0]       PC,
   output logic [31:0]       Inst,
   output logic              AddrErr,
   input  logic              LoadValid,
   input  logic [31:0]       LoadData,
   input  logic              LoadLast,
   output logic              LoadReady,
   output logic              CoreHold,
   output logic [ADDR_W:0]   LoadCount
);

   import iram_responder_pkg::state_t;
   import iram_responder_pkg::LOAD;
   import iram_responder_pkg::RUN;

   state_t            state;
   state_t            state_next;
   logic              xfer;
   logic              full;
   logic [ADDR_W:0]   load_count;
   logic              addr_err;
   logic              inst_nop;
   logic [ADDR_W-1:0] rd_index;
   logic              rd_err;
   logic              rd_en;
   logic [31:0]       rdata;

   // load_count doubles as the write pointer; its low bits address the next free word
   assign full     = (load_count[ADDR_W-1:0] == {ADDR_W{1'b1}});
   assign rd_index = PC[ADDR_W+1:2];
   assign rd_err   = (PC[1:0] != 2'b00) || (|PC[31:ADDR_W+2]) ||
                     ({1'b0, rd_index} >= load_count);
   assign rd_en    = (state == RUN) && IRead && !rd_err;

   // Next-state and load handshake decode.
   always_comb begin
      state_next = state;
      LoadReady  = 1'b0;
      xfer       = 1'b0;
      case (state)
         LOAD: begin
            LoadReady = ~Reset;
            xfer      = LoadValid & ~Reset;
            if (xfer && (LoadLast || full)) begin
               state_next = RUN;
            end else begin
               state_next = LOAD;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // State, load counter and read-status registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= LOAD;
         load_count <= '0;
         addr_err   <= 1'b0;
         inst_nop   <= 1'b1;
      end else begin
         state <= state_next;
         if (xfer) begin
            load_count <= load_count + (ADDR_W+1)'(1);
         end
         if (state == LOAD) begin
            addr_err <= 1'b0;
            inst_nop <= 1'b1;
         end else if (IRead) begin
            addr_err <= rd_err;
            inst_nop <= rd_err;
         end
      end
   end

   iram_array #(.ADDR_W(ADDR_W)) u_array (
      .Clk   (Clk),
      .WE    (xfer),
      .WAddr (load_count[ADDR_W-1:0]),
      .WData (LoadData),
      .RE    (rd_en),
      .RAddr (rd_index),
      .RData (rdata)
   );

   // RAM data is only trusted after a valid read; otherwise the NOP word is forced
   assign Inst      = inst_nop ? NOP_WORD : rdata;
   assign AddrErr   = addr_err;
   assign CoreHold  = (state == LOAD);
   assign LoadCount = load_count;

endmodule

// File: tb/tb_iram_responder.sv
// Scoreboard bench for iram_responder: expected read results are queued as reads are
// issued and compared when the registered response appears.
module tb_iram_responder;

   localparam int ADDR_W = 8;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              IRead;
   logic [31:0]       PC;
   logic [31:0]       Inst;
   logic              AddrErr;
   logic              LoadValid;
   logic [31:0]       LoadData;
   logic              LoadLast;
   logic              LoadReady;
   logic              CoreHold;
   logic [ADDR_W:0]   LoadCount;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_mem [256];
   int          model_cnt = 0;
   logic [31:0] exp_inst_q [$];
   logic        exp_err_q  [$];

   iram_responder #(.ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0000)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .IRead     (IRead),
      .PC        (PC),
      .Inst      (Inst),
      .AddrErr   (AddrErr),
      .LoadValid (LoadValid),
      .LoadData  (LoadData),
      .LoadLast  (LoadLast),
      .LoadReady (LoadReady),
      .CoreHold  (CoreHold),
      .LoadCount (LoadCount)
   );

   always #5 Clk = ~Clk;

   // One rising edge, then park on the falling edge where inputs change and outputs are sampled.
   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      LoadValid = 1'b1;
      LoadData  = d;
      LoadLast  = last;
      model_mem[model_cnt] = d;
      model_cnt++;
      tick();
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
   endtask

   task automatic push_expect(input logic [31:0] pc);
      logic        err;
      logic [31:0] idx;
      idx = {2'b00, pc[31:2]};
      err = (pc[1:0] != 2'b00) || (pc >= 32'h0000_0400) || (idx >= 32'(model_cnt));
      exp_err_q.push_back(err);
      exp_inst_q.push_back(err ? 32'h0000_0000 : model_mem[idx[7:0]]);
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      model_cnt = 0;
   endtask

   // Issue a burst of reads with IRead held high and score each response.
   task automatic run_reads(input string name, input logic [31:0] pcs [$]);
      logic [31:0] ei;
      logic        ee;
      IRead = 1'b1;
      foreach (pcs[k]) begin
         PC = pcs[k];
         push_expect(pcs[k]);
         tick();
         ei = exp_inst_q.pop_front();
         ee = exp_err_q.pop_front();
         total++;
         if (Inst !== ei) begin
            bad++;
            $display("FAIL %s inst pc=%h got=%h want=%h", name, pcs[k], Inst, ei);
         end
         total++;
         if (AddrErr !== ee) begin
            bad++;
            $display("FAIL %s err pc=%h got=%b want=%b", name, pcs[k], AddrErr, ee);
         end
      end
      IRead = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      total++;
      if ({Inst, AddrErr, LoadCount, CoreHold, LoadReady} !== {32'h0, 1'b0, 9'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_state got inst=%h err=%b cnt=%0d hold=%b rdy=%b want 0/0/0/1/0",
                  Inst, AddrErr, LoadCount, CoreHold, LoadReady);
      end
      Reset = 1'b0;
      model_cnt = 0;
      #1;
      total++;
      if (LoadReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", LoadReady);
      end
   endtask

   task automatic test_load_basic();
      logic [31:0] prog [4] = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0000};
      logic [31:0] pcs [$];
      for (int i = 0; i < 3; i++) load_word(prog[i], 1'b0);
      total++;
      if (CoreHold !== 1'b1 || LoadCount !== 9'd3) begin
         bad++;
         $display("FAIL load_mid hold=%b cnt=%0d want hold=1 cnt=3", CoreHold, LoadCount);
      end
      load_word(prog[3], 1'b1);
      total++;
      if (CoreHold !== 1'b0 || LoadCount !== 9'd4 || LoadReady !== 1'b0) begin
         bad++;
         $display("FAIL load_done hold=%b cnt=%0d rdy=%b want 0/4/0", CoreHold, LoadCount, LoadReady);
      end
      pcs = '{32'h8};
      run_reads("read_basic", pcs);
   endtask

   task automatic test_errors();
      logic [31:0] pcs [$];
      pcs = '{32'h6, 32'h4, 32'h10, 32'h400, 32'hC, 32'h8000_0000, 32'h0, 32'h1};
      run_reads("errors", pcs);
   endtask

   task automatic test_idle_hold();
      logic [31:0] pcs [$];
      pcs = '{32'h4};
      run_reads("hold_pre", pcs);
      for (int i = 0; i < 5; i++) begin
         PC = 32'(i * 4 + 8);
         tick();
         total++;
         if (Inst !== 32'h2002_0007 || AddrErr !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold cyc=%0d inst=%h err=%b want 20020007/0", i, Inst, AddrErr);
         end
      end
      pcs = '{32'h2};
      run_reads("hold_err_pre", pcs);
      PC = 32'h0;
      tick();
      total++;
      if (Inst !== 32'h0 || AddrErr !== 1'b1) begin
         bad++;
         $display("FAIL idle_hold_err inst=%h err=%b want 00000000/1", Inst, AddrErr);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [$];
      pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'hC, 32'h5, 32'h8};
      run_reads("b2b", pcs);
   endtask

   task automatic test_full_load();
      logic [31:0] pcs [$];
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         load_word(32'hA500_0000 ^ (32'(i) * 32'h0001_0103), 1'b0);
         if (i == 254) begin
            total++;
            if (CoreHold !== 1'b1 || LoadReady !== 1'b1) begin
               bad++;
               $display("FAIL full_mid hold=%b rdy=%b want 1/1", CoreHold, LoadReady);
            end
         end
      end
      total++;
      if (CoreHold !== 1'b0 || LoadCount !== 9'd256 || LoadReady !== 1'b0) begin
         bad++;
         $display("FAIL full_done hold=%b cnt=%0d rdy=%b want 0/256/0", CoreHold, LoadCount, LoadReady);
      end
      LoadValid = 1'b1;
      LoadData  = 32'hDEAD_BEEF;
      LoadLast  = 1'b1;
      tick();
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      total++;
      if (LoadCount !== 9'd256) begin
         bad++;
         $display("FAIL full_ignore cnt=%0d want 256", LoadCount);
      end
      pcs = '{32'h3FC, 32'h0, 32'h200, 32'h400};
      run_reads("full_read", pcs);
   endtask

   task automatic test_reset_midrun();
      logic [31:0] pcs [$];
      apply_reset();
      total++;
      if (CoreHold !== 1'b1 || Inst !== 32'h0 || LoadCount !== 9'd0 || AddrErr !== 1'b0) begin
         bad++;
         $display("FAIL midrun_reset hold=%b inst=%h cnt=%0d err=%b want 1/0/0/0",
                  CoreHold, Inst, LoadCount, AddrErr);
      end
      load_word(32'h1111_1111, 1'b0);
      load_word(32'h2222_2222, 1'b1);
      pcs = '{32'h0, 32'h4, 32'h8};
      run_reads("reload", pcs);
   endtask

   task automatic test_load_with_iread();
      logic [31:0] pcs [$];
      apply_reset();
      IRead = 1'b1;
      PC    = 32'h0;
      load_word(32'h3333_3333, 1'b0);
      total++;
      if (Inst !== 32'h0 || AddrErr !== 1'b0) begin
         bad++;
         $display("FAIL iread_in_load inst=%h err=%b want 00000000/0", Inst, AddrErr);
      end
      load_word(32'h4444_4444, 1'b1);
      IRead = 1'b0;
      total++;
      if (Inst !== 32'h0 || AddrErr !== 1'b0 || CoreHold !== 1'b0) begin
         bad++;
         $display("FAIL iread_with_last inst=%h err=%b hold=%b want 00000000/0/0",
                  Inst, AddrErr, CoreHold);
      end
      pcs = '{32'h0, 32'h4};
      run_reads("after_last", pcs);
   endtask

   initial begin
      Reset     = 1'b1;
      IRead     = 1'b0;
      PC        = 32'h0;
      LoadValid = 1'b0;
      LoadData  = 32'h0;
      LoadLast  = 1'b0;
      test_reset();
      test_load_basic();
      test_errors();
      test_idle_hold();
      test_back_to_back();
      test_full_load();
      test_reset_midrun();
      test_load_with_iread();
      total++;
      if (exp_inst_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_inst_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
